// File: rtl/n_bit_pipelined_csa_adder.sv
// Pipelined carry-select adder: fixed-width blocks chained in groups between
// pipeline registers, with operand skew and sum deskew so each result is aligned.
module n_bit_pipelined_csa_adder #(
    parameter int IN_DATAWIDTH     = 16,
    parameter int OUT_DATAWIDTH    = IN_DATAWIDTH + 1,
    parameter int BLOCK_WIDTH      = 2,
    parameter int BLOCKS_PER_STAGE = 2,
    parameter int SIGNED           = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ce,
    input  logic                     in_valid,
    input  logic [IN_DATAWIDTH-1:0]  in1,
    input  logic [IN_DATAWIDTH-1:0]  in2,
    input  logic                     cin,
    output logic                     out_valid,
    output logic [OUT_DATAWIDTH-1:0] sum
);

    localparam int W          = IN_DATAWIDTH;
    localparam int NUM_BLOCKS = (W + BLOCK_WIDTH - 1) / BLOCK_WIDTH;
    localparam int LATENCY    = (NUM_BLOCKS + BLOCKS_PER_STAGE - 1) / BLOCKS_PER_STAGE;
    localparam int STAGE_BITS = BLOCK_WIDTH * BLOCKS_PER_STAGE;

`ifndef SYNTHESIS
    initial begin
        if (BLOCK_WIDTH < 1 || BLOCK_WIDTH > IN_DATAWIDTH || BLOCKS_PER_STAGE < 1 ||
            OUT_DATAWIDTH != IN_DATAWIDTH + 1) begin
            $display("n_bit_pipelined_csa_adder: illegal parameters W=%0d BW=%0d BPS=%0d OW=%0d",
                     IN_DATAWIDTH, BLOCK_WIDTH, BLOCKS_PER_STAGE, OUT_DATAWIDTH);
            $finish;
        end
    end
`endif

    logic [LATENCY-1:0] valid_pipe;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_pipe <= '0;
        end else if (ce) begin
            valid_pipe[0] <= in_valid;
            for (int unsigned i = 1; i < LATENCY; i++) begin
                valid_pipe[i] <= valid_pipe[i-1];
            end
        end
    end

    assign out_valid = valid_pipe[LATENCY-1];

    for (genvar s = 0; s < LATENCY; s++) begin : g_stage
        localparam int LO   = s * STAGE_BITS;
        localparam int HI   = (LO + STAGE_BITS < W) ? LO + STAGE_BITS : W;
        localparam int SW   = HI - LO;
        localparam int NBLK = (SW + BLOCK_WIDTH - 1) / BLOCK_WIDTH;
        localparam bit LAST = (s == LATENCY - 1);

        // a/b hold operand bits from LO upward; low_sum holds result bits [HI-1:0]
        logic [W-LO-1:0] a;
        logic [W-LO-1:0] b;
        logic            carry_in;
        logic [SW-1:0]   blk_sum;
        logic [HI-1:0]   low_sum;
        logic            stage_cout;

        if (s == 0) begin : g_src
            assign a        = in1;
            assign b        = in2;
            assign carry_in = cin;
            assign low_sum  = blk_sum;
        end else begin : g_src
            assign a        = g_stage[s-1].g_reg.a_q;
            assign b        = g_stage[s-1].g_reg.b_q;
            assign carry_in = g_stage[s-1].g_reg.carry_q;
            assign low_sum  = {blk_sum, g_stage[s-1].g_reg.sum_q};
        end

        for (genvar k = 0; k < NBLK; k++) begin : g_blk
            localparam int BLO = k * BLOCK_WIDTH;
            localparam int BHI = (BLO + BLOCK_WIDTH < SW) ? BLO + BLOCK_WIDTH : SW;
            localparam int BW  = BHI - BLO;

            logic [BW:0] r0;
            logic [BW:0] r1;
            logic        sel;
            logic        cout;

            if (k == 0) begin : g_cin
                assign sel = carry_in;
            end else begin : g_cin
                assign sel = g_blk[k-1].cout;
            end

            assign r0 = {1'b0, a[BHI-1:BLO]} + {1'b0, b[BHI-1:BLO]};
            assign r1 = {1'b0, a[BHI-1:BLO]} + {1'b0, b[BHI-1:BLO]} + {{BW{1'b0}}, 1'b1};
            assign blk_sum[BHI-1:BLO] = sel ? r1[BW-1:0] : r0[BW-1:0];
            assign cout               = sel ? r1[BW]     : r0[BW];
        end

        assign stage_cout = g_blk[NBLK-1].cout;

        if (!LAST) begin : g_reg
            logic [W-HI-1:0] a_q;
            logic [W-HI-1:0] b_q;
            logic [HI-1:0]   sum_q;
            logic            carry_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    a_q     <= '0;
                    b_q     <= '0;
                    sum_q   <= '0;
                    carry_q <= 1'b0;
                end else if (ce) begin
                    a_q     <= a[W-LO-1:SW];
                    b_q     <= b[W-LO-1:SW];
                    sum_q   <= low_sum;
                    carry_q <= stage_cout;
                end
            end
        end else begin : g_out
            // Signed MSB equals the sign-extended sum bit, so no overflow case exists.
            logic msb;
            assign msb = (SIGNED != 0) ? (a[SW-1] ^ b[SW-1] ^ stage_cout) : stage_cout;

            always_ff @(posedge clk) begin
                if (rst) begin
                    sum <= '0;
                end else if (ce) begin
                    sum <= {msb, low_sum};
                end
            end
        end
    end

endmodule
